// File: rtl/knn_vote.sv
// k-NN majority vote: collects K ranked neighbour labels, then scans
// the per-class tallies to pick the most frequent, nearest-first label.
// Ports:
//   clk, rst (sync, active-low), start
//   nb_valid / nb_data / nb_ready : neighbour entry stream, rank 0 first
//   busy        : high while loading or scanning
//   label_valid : label_out holds a final result
//   label_out   : winning label, 8'hFF when no entry was votable
//   err         : sticky out-of-range label flag for this classification
module knn_vote #(
    parameter int DATA_W    = 32,
    parameter int K         = 4,
    parameter int data_info = 40,
    parameter int NCLASS    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 nb_valid,
    input  logic [data_info-1:0] nb_data,
    output logic                 nb_ready,
    output logic                 busy,
    output logic                 label_valid,
    output logic [7:0]           label_out,
    output logic                 err
);

    localparam int CW = $clog2(K + 1);
    localparam int RW = (K > 1) ? $clog2(K) : 1;
    localparam int SW = (NCLASS > 1) ? $clog2(NCLASS) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, SCAN, DONE} state_t;

    state_t state_q, state_d;
    logic [NCLASS-1:0][CW-1:0] cnt_q, cnt_d;
    logic [NCLASS-1:0][RW-1:0] frank_q, frank_d;
    logic [CW-1:0] acc_q, acc_d;
    logic [SW-1:0] scan_q, scan_d;
    logic [CW-1:0] best_cnt_q, best_cnt_d;
    logic [RW-1:0] best_rank_q, best_rank_d;
    logic [7:0]    best_lbl_q, best_lbl_d;
    logic          lv_q, lv_d;
    logic [7:0]    lbl_q, lbl_d;
    logic          err_q, err_d;

    // Distance is carried for the producer's ordering only; not voted on.
    logic [DATA_W-1:0] unused_dist;
    assign unused_dist = nb_data[data_info-1:8];

    logic [7:0]    nb_lbl;
    logic [RW-1:0] rank;
    logic [CW-1:0] cur_cnt;
    logic [RW-1:0] cur_rank;
    logic          take;
    logic          in_range;

    assign nb_lbl      = nb_data[7:0];
    assign rank        = acc_q[RW-1:0];
    assign nb_ready    = (state_q == LOAD);
    assign busy        = (state_q == LOAD) || (state_q == SCAN);
    assign label_valid = lv_q;
    assign label_out   = lbl_q;
    assign err         = err_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        frank_d     = frank_q;
        acc_d       = acc_q;
        scan_d      = scan_q;
        best_cnt_d  = best_cnt_q;
        best_rank_d = best_rank_q;
        best_lbl_d  = best_lbl_q;
        lv_d        = lv_q;
        lbl_d       = lbl_q;
        err_d       = err_q;
        in_range    = 1'b0;
        cur_cnt     = cnt_q[scan_q];
        cur_rank    = frank_q[scan_q];
        // Equal count only wins if it first appeared at a nearer rank.
        take = (cur_cnt > best_cnt_q) ||
               ((cur_cnt == best_cnt_q) && (best_cnt_q != '0) &&
                (cur_rank < best_rank_q));

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    frank_d = '0;
                    acc_d   = '0;
                    err_d   = 1'b0;
                    lv_d    = 1'b0;
                end
            end
            LOAD: begin
                if (nb_valid) begin
                    for (int c = 0; c < NCLASS; c++) begin
                        if (nb_lbl == 8'(c)) begin
                            in_range = 1'b1;
                            if (cnt_q[c] == '0) frank_d[c] = rank;
                            cnt_d[c] = cnt_q[c] + CW'(1);
                        end
                    end
                    if (!in_range) err_d = 1'b1;
                    acc_d = acc_q + CW'(1);
                    if (acc_q == CW'(K - 1)) begin
                        state_d     = SCAN;
                        scan_d      = '0;
                        best_cnt_d  = '0;
                        best_rank_d = '0;
                        best_lbl_d  = '0;
                    end
                end
            end
            SCAN: begin
                if (take) begin
                    best_cnt_d  = cur_cnt;
                    best_rank_d = cur_rank;
                    best_lbl_d  = 8'(scan_q);
                end
                scan_d = scan_q + SW'(1);
                if (scan_q == SW'(NCLASS - 1)) begin
                    state_d = DONE;
                    lv_d    = 1'b1;
                    if (best_cnt_d == '0) begin
                        lbl_d = 8'hFF;
                        err_d = 1'b1;
                    end else begin
                        lbl_d = best_lbl_d;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            frank_q     <= '0;
            acc_q       <= '0;
            scan_q      <= '0;
            best_cnt_q  <= '0;
            best_rank_q <= '0;
            best_lbl_q  <= '0;
            lv_q        <= 1'b0;
            lbl_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            frank_q     <= frank_d;
            acc_q       <= acc_d;
            scan_q      <= scan_d;
            best_cnt_q  <= best_cnt_d;
            best_rank_q <= best_rank_d;
            best_lbl_q  <= best_lbl_d;
            lv_q        <= lv_d;
            lbl_q       <= lbl_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_knn_vote.sv
// Self-checking bench for knn_vote (K=4, NCLASS=16).
// Expected {err,label} queued at start, compared when label_valid rises.
module tb_knn_vote;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        nb_valid = 1'b0;
    logic [39:0] nb_data = '0;
    logic        nb_ready;
    logic        busy;
    logic        label_valid;
    logic [7:0]  label_out;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;
    logic [8:0] exp_q[$];

    always #5 clk = ~clk;

    knn_vote dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .nb_valid   (nb_valid),
        .nb_data    (nb_data),
        .nb_ready   (nb_ready),
        .busy       (busy),
        .label_valid(label_valid),
        .label_out  (label_out),
        .err        (err)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0][7:0] mk(input logic [7:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    // Walk ranks nearest first; strict > keeps the earliest label on ties.
    function automatic logic [8:0] model(input logic [3:0][7:0] l);
        logic [7:0] win;
        int         bc;
        int         n;
        logic       e;
        win = 8'hFF;
        bc  = 0;
        e   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (l[i] >= 8'd16) begin
                e = 1'b1;
            end else begin
                n = 0;
                for (int j = 0; j < 4; j++) if (l[j] == l[i]) n++;
                if (n > bc) begin
                    bc  = n;
                    win = l[i];
                end
            end
        end
        if (bc == 0) e = 1'b1;
        return {e, win};
    endfunction

    task automatic feed(input logic [3:0][7:0] l, input int cnt,
                        input bit gaps, input bit noise);
        for (int i = 0; i < cnt; i++) begin
            if (gaps && i > 0) begin
                nb_valid = 1'b0;
                nb_data  = {$urandom(), 8'($urandom_range(0, 15))};
                repeat (2) tick;
            end
            nb_valid = 1'b1;
            nb_data  = {$urandom(), l[i]};
            if (noise && i == 1) start = 1'b1;
            chk("nb_ready", {31'd0, nb_ready}, 1);
            tick;
            nb_valid = 1'b0;
            start    = 1'b0;
        end
    endtask

    task automatic run(input logic [3:0][7:0] l, input bit gaps,
                       input bit noise);
        int         n;
        logic [8:0] e;
        start = 1'b1;
        tick;
        start = 1'b0;
        exp_q.push_back(model(l));
        chk("lv_clr", {31'd0, label_valid}, 0);
        chk("busy_load", {31'd0, busy}, 1);
        chk("err_clr", {31'd0, err}, 0);
        feed(l, 4, gaps, noise);
        chk("busy_scan", {31'd0, busy}, 1);
        chk("ready_scan", {31'd0, nb_ready}, 0);
        n = 1;
        while (!label_valid && n < 40) begin
            if (noise && n == 5) start = 1'b1;
            tick;
            start = 1'b0;
            n++;
        end
        chk("latency", n, 17);
        chk("lv", {31'd0, label_valid}, 1);
        chk("busy_done", {31'd0, busy}, 0);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("label", {24'd0, label_out}, {24'd0, e[7:0]});
            chk("err", {31'd0, err}, {31'd0, e[8]});
            repeat (3) tick;
            chk("lv_hold", {31'd0, label_valid}, 1);
            chk("label_hold", {24'd0, label_out}, {24'd0, e[7:0]});
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ready"}, {31'd0, nb_ready}, 0);
        chk({tag, "_busy"}, {31'd0, busy}, 0);
        chk({tag, "_lv"}, {31'd0, label_valid}, 0);
        chk({tag, "_label"}, {24'd0, label_out}, 0);
        chk({tag, "_err"}, {31'd0, err}, 0);
    endtask

    task automatic hit_reset;
        rst      = 1'b0;
        start    = 1'b1;
        nb_valid = 1'b1;
        nb_data  = {32'd0, 8'd3};
        tick;
        rst      = 1'b1;
        start    = 1'b0;
        nb_valid = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        rst = 1'b0;
        repeat (2) tick;
        chk_reset("rst0");
        rst = 1'b1;
        tick;

        run(mk(3, 3, 5, 7), 0, 0);
        run(mk(5, 2, 2, 5), 0, 0);
        run(mk(9, 1, 4, 6), 0, 0);
        run(mk(6, 6, 6, 1), 0, 0);
        run(mk(20, 4, 20, 20), 0, 0);
        run(mk(200, 201, 202, 203), 0, 0);
        run(mk(3, 3, 5, 7), 1, 0);
        run(mk(5, 2, 2, 5), 1, 0);

        // Abort mid-LOAD after two accepts, one of them out of range.
        start = 1'b1;
        tick;
        start = 1'b0;
        feed(mk(20, 2, 0, 0), 2, 0, 0);
        hit_reset();
        chk_reset("rst_load");
        repeat (20) tick;
        chk("rst_load_nolv", {31'd0, label_valid}, 0);
        run(mk(4, 9, 9, 4), 0, 0);

        // Abort mid-SCAN.
        start = 1'b1;
        tick;
        start = 1'b0;
        feed(mk(7, 7, 7, 7), 4, 0, 0);
        repeat (5) tick;
        hit_reset();
        chk_reset("rst_scan");
        repeat (20) tick;
        chk("rst_scan_nolv", {31'd0, label_valid}, 0);

        run(mk(1, 7, 7, 1), 0, 1);
        run(mk(12, 0, 15, 0), 1, 1);
        run(mk(15, 14, 13, 12), 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
